// File: rtl/imm_encoder_if.sv
// Request/result bundle for the immediate encoder.
// IMM_ENC_ROUNDTRIP_CHECK_EN adds the rt_mismatch result flag.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [31:0] imm;
    logic [2:0]  Imm_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_imm_err;
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic        rt_mismatch;

    modport master (
        output in_valid, base_instr, imm, Imm_op, out_ready,
        input  in_ready, out_valid, out_instr, out_imm_err, rt_mismatch
    );
    modport slave (
        input  in_valid, base_instr, imm, Imm_op, out_ready,
        output in_ready, out_valid, out_instr, out_imm_err, rt_mismatch
    );
`else
    modport master (
        output in_valid, base_instr, imm, Imm_op, out_ready,
        input  in_ready, out_valid, out_instr, out_imm_err
    );
    modport slave (
        input  in_valid, base_instr, imm, Imm_op, out_ready,
        output in_ready, out_valid, out_instr, out_imm_err
    );
`endif
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into the RV32I immediate fields of a base instruction (2-stage pipe).
// Optional round-trip self-check: define IMM_ENC_ROUNDTRIP_CHECK_EN.
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    imm_encoder_if.slave         bus,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam logic [2:0] OP_I = 3'b001;
    localparam logic [2:0] OP_S = 3'b010;
    localparam logic [2:0] OP_B = 3'b011;
    localparam logic [2:0] OP_U = 3'b100;
    localparam logic [2:0] OP_J = 3'b101;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1'b1);

    function automatic logic imm_err(input logic [2:0] op, input logic [31:0] v);
        logic e;
        case (op)
            OP_I, OP_S: e = !((&v[31:11]) || (~|v[31:11]));
            OP_B:       e = !((&v[31:12]) || (~|v[31:12])) || v[0];
            OP_U:       e = |v[11:0];
            OP_J:       e = !((&v[31:20]) || (~|v[31:20])) || v[0];
            default:    e = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pack_imm(input logic [31:0] base, input logic [31:0] v,
                                             input logic [2:0] op);
        logic [31:0] r;
        r = base;
        case (op)
            OP_I: r[31:20] = v[11:0];
            OP_S: begin
                r[31:25] = v[11:5];
                r[11:7]  = v[4:0];
            end
            OP_B: begin
                r[31]    = v[12];
                r[30:25] = v[10:5];
                r[11:8]  = v[4:1];
                r[7]     = v[11];
            end
            OP_U: r[31:12] = v[31:12];
            OP_J: begin
                r[31]    = v[20];
                r[30:21] = v[10:1];
                r[20]    = v[11];
                r[19:12] = v[19:12];
            end
            default: r = base;
        endcase
        return r;
    endfunction

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    // Formats without an immediate extract the request value so they never flag a mismatch.
    function automatic logic [31:0] extract_imm(input logic [31:0] i, input logic [2:0] op,
                                                input logic [31:0] req);
        logic [31:0] x;
        case (op)
            OP_I:    x = {{20{i[31]}}, i[31:20]};
            OP_S:    x = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_B:    x = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_U:    x = {i[31:12], 12'h000};
            OP_J:    x = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: x = req;
        endcase
        return x;
    endfunction
`endif

    logic        s1_valid_r;
    logic [31:0] s1_base_r;
    logic [31:0] s1_imm_r;
    logic [2:0]  s1_op_r;
    logic        s1_err_r;
    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic        out_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;
    logic        s2_accept_s;
    logic        in_ready_s;
    logic        bump_s;
    logic [31:0] packed_s;

    assign s2_accept_s = !out_valid_r || bus.out_ready;
    assign in_ready_s  = !s1_valid_r || s2_accept_s;
    assign packed_s    = pack_imm(s1_base_r, s1_imm_r, s1_op_r);

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_instr   = out_instr_r;
    assign bus.out_imm_err = out_err_r;
    assign err_count       = err_cnt_r;

    // Stage 1: capture the request and classify its range.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_base_r  <= 32'h0000_0000;
            s1_imm_r   <= 32'h0000_0000;
            s1_op_r    <= 3'b000;
            s1_err_r   <= 1'b0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_base_r <= bus.base_instr;
                s1_imm_r  <= bus.imm;
                s1_op_r   <= bus.Imm_op;
                s1_err_r  <= imm_err(bus.Imm_op, bus.imm);
            end
        end
    end

`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
    logic rt_r;
    assign bus.rt_mismatch = rt_r;

    // Round-trip flag travels with the stage-2 result.
    always_ff @(posedge clk) begin
        if (rst) begin
            rt_r <= 1'b0;
        end else if (s2_accept_s && s1_valid_r) begin
            rt_r <= !s1_err_r && (extract_imm(packed_s, s1_op_r, s1_imm_r) != s1_imm_r);
        end
    end
`endif

    // Stage 2: packed result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_err_r   <= 1'b0;
        end else if (s2_accept_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_instr_r <= packed_s;
                out_err_r   <= s1_err_r;
            end
        end
    end

    // Count flagged results only when they are actually delivered.
    always_comb begin
        bump_s = 1'b0;
        if (out_valid_r && bus.out_ready) begin
`ifdef IMM_ENC_ROUNDTRIP_CHECK_EN
            bump_s = out_err_r || rt_r;
`else
            bump_s = out_err_r;
`endif
        end else begin
            bump_s = 1'b0;
        end
    end

    // Saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (bump_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: per-cycle model compare plus directed literal vectors.
module tb_imm_encoder;
    localparam int W    = 2;
    localparam int CMAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] err_count;

    imm_encoder_if bus();

    imm_encoder #(.ERR_CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit started = 1'b0;
    int mcnt    = 0;
    bit m_ready;
    bit m_ov;

    logic [31:0] q_instr[$];
    bit          q_err[$];
    int          q_cap[$];
    logic [31:0] got[$];
    int          got_cyc[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Which immediate bit lands at instruction bit pos, or -1 when pos keeps the base bit.
    function automatic int src_bit(input logic [2:0] op, input int pos);
        case (op)
            3'b001: return (pos >= 20) ? pos - 20 : -1;
            3'b010: begin
                if (pos >= 25) return pos - 20;
                else if (pos >= 7 && pos <= 11) return pos - 7;
                else return -1;
            end
            3'b011: begin
                if (pos == 31) return 12;
                else if (pos >= 25) return pos - 20;
                else if (pos >= 8 && pos <= 11) return pos - 7;
                else if (pos == 7) return 11;
                else return -1;
            end
            3'b100: return (pos >= 12) ? pos : -1;
            3'b101: begin
                if (pos == 31) return 20;
                else if (pos >= 21) return pos - 20;
                else if (pos == 20) return 11;
                else if (pos >= 12) return pos;
                else return -1;
            end
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] model_instr(input logic [31:0] b, input logic [31:0] im,
                                                input logic [2:0] op);
        logic [31:0] r;
        for (int p = 0; p < 32; p++) begin
            int s;
            s = src_bit(op, p);
            r[p] = (s < 0) ? b[p] : im[s];
        end
        return r;
    endfunction

    function automatic bit model_err(input logic [31:0] im, input logic [2:0] op);
        longint v;
        v = longint'($signed(im));
        case (op)
            3'b001, 3'b010: return (v < -2048) || (v > 2047);
            3'b011:         return (v < -4096) || (v > 4095) || (im[0] == 1'b1);
            3'b100:         return (im % 32'd4096) != 32'd0;
            3'b101:         return (v < -(64'sd1 << 20)) || (v > (64'sd1 << 20) - 1) || (im[0] == 1'b1);
            default:        return 1'b0;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison against the transaction-level model.
    initial forever begin
        @(negedge clk);
        m_ready = 1'b1;
        m_ov    = 1'b0;
        if (started) begin
            m_ready = (q_instr.size() < 2) || bus.out_ready;
            if (q_instr.size() > 0) m_ov = (cyc - q_cap[0]) >= 1;
            check("in_ready", 32'(bus.in_ready), 32'(m_ready));
            check("out_valid", 32'(bus.out_valid), 32'(m_ov));
            if (m_ov && bus.out_valid) begin
                check("out_instr", bus.out_instr, q_instr[0]);
                check("out_imm_err", 32'(bus.out_imm_err), 32'(q_err[0]));
            end
            check("err_count", 32'(err_count), 32'(mcnt));
        end
        if (rst) begin
            q_instr.delete();
            q_err.delete();
            q_cap.delete();
            mcnt    = 0;
            started = 1'b1;
        end else if (started) begin
            if (m_ov && bus.out_ready) begin
                got.push_back(bus.out_instr);
                got_cyc.push_back(cyc);
                if (q_err[0] && mcnt < CMAX) mcnt++;
                void'(q_instr.pop_front());
                void'(q_err.pop_front());
                void'(q_cap.pop_front());
            end
            if (bus.in_valid && m_ready) begin
                q_instr.push_back(model_instr(bus.base_instr, bus.imm, bus.Imm_op));
                q_err.push_back(model_err(bus.imm, bus.Imm_op));
                q_cap.push_back(cyc + 1);
            end
        end
    end

    // Presents a request and returns just after the edge that accepts it; in_valid stays high.
    task automatic push(input logic [31:0] b, input logic [31:0] im, input logic [2:0] op);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.base_instr = b;
        bus.imm        = im;
        bus.Imm_op     = op;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 20);
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic [31:0] b, input logic [31:0] im,
                        input logic [2:0] op, input logic [31:0] exp_i, input bit exp_e);
        int n;
        push(b, im, op);
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 10);
        check({name, "_latency"}, 32'(n), 32'd2);
        check({name, "_instr"}, bus.out_instr, exp_i);
        check({name, "_err"}, 32'(bus.out_imm_err), 32'(exp_e));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cnt(input string name, input int v);
        @(negedge clk);
        check(name, 32'(err_count), 32'(v));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.base_instr = 32'h0000_0000;
        bus.imm        = 32'h0000_0000;
        bus.Imm_op     = 3'b000;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'h0000_0000);
        check("rst_out_err", 32'(bus.out_imm_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;

        send("i_neg1", 32'h0000_0093, 32'hFFFF_FFFF, 3'b001, 32'hFFF0_0093, 1'b0);
        send("s_8",    32'h0020_A023, 32'h0000_0008, 3'b010, 32'h0020_A423, 1'b0);
        send("b_m4",   32'h0000_0063, 32'hFFFF_FFFC, 3'b011, 32'hFE00_0EE3, 1'b0);
        send("j_800",  32'h0000_00EF, 32'h0000_0800, 3'b101, 32'h0010_00EF, 1'b0);
        send("u_odd",  32'h0000_0037, 32'h1234_5001, 3'b100, 32'h1234_5037, 1'b1);
        expect_cnt("cnt_after_u", 1);
        send("i_800",  32'h0000_0013, 32'h0000_0800, 3'b001, 32'h8000_0013, 1'b1);
        send("b_3",    32'h0000_0063, 32'h0000_0003, 3'b011, 32'h0000_0163, 1'b1);
        expect_cnt("cnt_three", 3);
        send("pass",   32'hDEAD_BEEF, 32'h1234_5678, 3'b000, 32'hDEAD_BEEF, 1'b0);
        send("u_fff",  32'h0000_0037, 32'h0000_0FFF, 3'b100, 32'h0000_0037, 1'b1);
        expect_cnt("cnt_sat4", 3);
        send("j_odd",  32'h0000_006F, 32'h0000_0001, 3'b101, 32'h0000_006F, 1'b1);
        expect_cnt("cnt_sat5", 3);

        // Backpressure: two accepted, third held off, first result frozen.
        got.delete();
        got_cyc.delete();
        bus.out_ready = 1'b0;
        push(32'h0000_0013, 32'h0000_0001, 3'b001);
        push(32'h0000_0013, 32'h0000_0002, 3'b001);
        bus.imm = 32'h0000_0003;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_hold_instr", bus.out_instr, 32'h0010_0013);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        push(32'h0000_0013, 32'h0000_0003, 3'b001);
        push(32'h0000_0013, 32'h0000_0004, 3'b001);
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            check("bp_order0", got[0], 32'h0010_0013);
            check("bp_order1", got[1], 32'h0020_0013);
            check("bp_order2", got[2], 32'h0030_0013);
            check("bp_order3", got[3], 32'h0040_0013);
            for (int k = 1; k < 4; k++)
                check("bp_rate", 32'(got_cyc[k] - got_cyc[k-1]), 32'd1);
        end

        // Reset with both stages occupied.
        bus.out_ready = 1'b0;
        push(32'h0000_0013, 32'h0000_0800, 3'b001);
        push(32'h0000_0013, 32'h0000_0005, 3'b001);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        check("pre_rst_cnt", 32'(err_count), 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send("post_rst", 32'h0000_0093, 32'hFFFF_FFFF, 3'b001, 32'hFFF0_0093, 1'b0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate-generation path. Takes a 32-bit immediate and a format code, and packs the immediate bits into the instruction-word positions of a base instruction.
- Sits in the instruction-assembly and self-test path. It lets the tooling, the trap/patch unit and the decoder regression loop build valid RV32I words from (base fields, immediate) pairs.
- Two-stage valid/ready pipeline with a representability check and an error counter.

Parameters:
- ERR_CNT_W, 8, width of the saturating immediate-error counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept this cycle
- base_instr  input  32  instruction word carrying opcode/rd/rs1/rs2/funct fields; immediate positions are don't-care
- imm  input  32  immediate value (sign-extended, byte offset for B/J)
- Imm_op  input  3  format: 001 I, 010 S, 011 B, 100 U, 101 J, others = no immediate
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_instr  output  32  encoded instruction
- out_imm_err  output  1  immediate not representable in selected format
- err_count  output  ERR_CNT_W  saturating count of accepted-and-delivered results with out_imm_err=1

Behaviour:
- Reset: out_valid=0, out_instr=0, out_imm_err=0, err_count=0, both stage valids=0. in_ready is 1 in the cycle after reset deasserts.
- Handshake: a transfer occurs when valid && ready on the same edge. Inputs are sampled only on an in transfer.
  - S1 advance: s2_accept = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_accept (combinational through out_ready; no skid).
- Latency: 2 cycles from in transfer to out_valid when unstalled. Throughput is 1 per cycle.
- While out_valid=1 && out_ready=0, out_instr and out_imm_err hold stable.
- Stage 1 registers base_instr, imm and Imm_op, and computes err. err is determined only by Imm_op and imm:
  - I, S: err unless imm[31:11] are all equal.
  - B: err unless imm[31:12] are all equal and imm[0]=0.
  - U: err unless imm[11:0]=0.
  - J: err unless imm[31:20] are all equal and imm[0]=0.
  - Other codes: err=0.
- Stage 2 produces out_instr = base_instr with only the format's immediate positions replaced; all other bits pass unchanged.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Other codes: out_instr=base_instr.
- Error case: the instruction is still packed from the truncated bits as above, and out_imm_err=1.
- err_count increments by 1 on each out transfer with out_imm_err=1, and saturates at all-ones (no wrap).
- Simultaneous events: out transfer and in transfer in the same cycle both complete, so the pipeline shifts.
- Reset mid-operation: in-flight requests are discarded and err_count clears. rst has priority over every other update.

Optional Feature:
- Macro IMM_ENC_ROUNDTRIP_CHECK_EN.
- When defined:
  - Stage 2 also re-extracts the immediate from out_instr using the standard RV32I decode rules, and adds output port rt_mismatch (1 bit).
  - rt_mismatch = (!err) && (extracted != imm). It registers with the result and holds while stalled.
  - Any rt_mismatch=1 on an out transfer also increments err_count.
- When undefined: port and logic are absent, and behaviour is identical otherwise.

Test Plan:
- I-type: base 0x00000093, imm 0xFFFFFFFF, Imm_op 001, out_ready=1 -> out_valid after 2 cycles, out_instr 0xFFF00093, err 0.
- S and B:
  - base 0x0020A023, imm 0x00000008, op 010 -> 0x0020A423.
  - Then base 0x00000063, imm 0xFFFFFFFC, op 011 -> 0xFE000EE3, err 0.
- J and U:
  - base 0x000000EF, imm 0x00000800, op 101 -> 0x001000EF.
  - Then base 0x00000037, imm 0x12345001, op 100 -> 0x12345037, err 1, err_count 1.
- Range/pass-through:
  - I imm 0x00000800 -> err 1.
  - B imm 0x00000003 -> err 1.
  - op 000 base 0xDEADBEEF -> 0xDEADBEEF, err 0.
- Backpressure: stream 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepted, out_instr stable. Release out_ready -> all 4 delivered in order, 1 per cycle, none lost or duplicated.
- Reset/saturation:
  - With ERR_CNT_W=2, deliver 5 error results -> err_count 3.
  - Assert rst with both stages full -> next cycle out_valid 0, err_count 0, in_ready 1.
